// File: rtl/led_breathe_pwm_pkg.sv
// led_pkg: phase encoding and default parameters
// shared by the breathing-LED top and its PWM generator.
package led_pkg;

  typedef enum logic [1:0] {
    RISE    = 2'b00,
    HOLD_HI = 2'b01,
    FALL    = 2'b10,
    HOLD_LO = 2'b11
  } phase_t;

  localparam int PWM_W_DEF      = 8;
  localparam int STEP_DEF       = 1;
  localparam int HOLD_TICKS_DEF = 4;

endpackage

// File: rtl/led_breathe_pwm_gen.sv
// led_pwm_gen: free-running PWM counter, duty compare, registered output.
// Ports: clk, rst, enable, duty[PWM_W] in; pwm_out out. Gamma: LED_BREATHE_GAMMA_EN.
module led_pwm_gen #(
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [PWM_W-1:0] duty,
  output logic             pwm_out
);

  logic [PWM_W-1:0] pwm_cnt;
  logic [PWM_W-1:0] duty_eff;

`ifdef LED_BREATHE_GAMMA_EN
  // Square law: upper half of duty^2 approximates perceived brightness.
  logic [2*PWM_W-1:0] duty_sq;
  assign duty_sq  = duty * duty;
  assign duty_eff = duty_sq[2*PWM_W-1:PWM_W];
`else
  assign duty_eff = duty;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
      pwm_out <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      pwm_out <= enable & (pwm_cnt < duty_eff);
    end
  end

endmodule

// File: rtl/led_breathe_pwm.sv
// led_breathe_pwm: turns blinker level edges into a rise/hold/fall/hold duty ramp.
// Ports: clk, rst, toggle_in, enable in; pwm_out, duty[PWM_W], phase[2] out. Gamma: LED_BREATHE_GAMMA_EN.
module led_breathe_pwm
  import led_pkg::*;
#(
  parameter int PWM_W      = PWM_W_DEF,
  parameter int STEP       = STEP_DEF,
  parameter int HOLD_TICKS = HOLD_TICKS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             toggle_in,
  input  logic             enable,
  output logic             pwm_out,
  output logic [PWM_W-1:0] duty,
  output logic [1:0]       phase
);

  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [HW-1:0] HOLD_LAST =
    HW'((HOLD_TICKS > 0) ? HOLD_TICKS - 1 : 0);
  localparam logic [PWM_W-1:0] MAX   = {PWM_W{1'b1}};
  localparam logic [PWM_W:0]   MAX_X = {1'b0, MAX};
  localparam logic [PWM_W:0]   STEP_X = (PWM_W+1)'(STEP);

  phase_t           state;
  logic [PWM_W-1:0] duty_q;
  logic [HW-1:0]    hold_cnt;
  logic             toggle_q;
  logic             tick;

  logic [PWM_W:0]   sum;
  logic [PWM_W:0]   diff;
  logic [PWM_W-1:0] rise_d;
  logic [PWM_W-1:0] fall_d;

  // toggle_q follows toggle_in even when disabled,
  // so re-enabling cannot see a stale edge.
  assign tick = (toggle_in ^ toggle_q) & enable;

  // One extra bit catches overflow and borrow for saturation.
  assign sum    = {1'b0, duty_q} + STEP_X;
  assign diff   = {1'b0, duty_q} - STEP_X;
  assign rise_d = (sum > MAX_X) ? MAX : sum[PWM_W-1:0];
  assign fall_d = diff[PWM_W] ? '0 : diff[PWM_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RISE;
      duty_q   <= '0;
      hold_cnt <= '0;
      toggle_q <= 1'b0;
    end else begin
      toggle_q <= toggle_in;
      if (tick) begin
        unique case (state)
          RISE: begin
            duty_q <= rise_d;
            if (rise_d == MAX) begin
              hold_cnt <= '0;
              state    <= (HOLD_TICKS == 0) ? FALL : HOLD_HI;
            end
          end
          HOLD_HI: begin
            if (hold_cnt == HOLD_LAST) begin
              hold_cnt <= '0;
              state    <= FALL;
            end else begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end
          FALL: begin
            duty_q <= fall_d;
            if (fall_d == '0) begin
              hold_cnt <= '0;
              state    <= (HOLD_TICKS == 0) ? RISE : HOLD_LO;
            end
          end
          HOLD_LO: begin
            if (hold_cnt == HOLD_LAST) begin
              hold_cnt <= '0;
              state    <= RISE;
            end else begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end
          default: state <= RISE;
        endcase
      end
    end
  end

  assign duty  = duty_q;
  assign phase = state;

  led_pwm_gen #(
    .PWM_W (PWM_W)
  ) u_pwm (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .duty    (duty_q),
    .pwm_out (pwm_out)
  );

endmodule

// File: tb/tb_led_breathe_pwm.sv
// tb_led_breathe_pwm: directed scoreboard bench over four parameterisations.
// Gamma expectations follow LED_BREATHE_GAMMA_EN.
module tb_led_breathe_pwm;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [3:0] tg;
  logic [3:0] pw;
  logic [7:0] d0, d3, d2, dn;
  logic [1:0] p0, p3, p2, pn;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  led_breathe_pwm u0 (
    .clk(clk), .rst(rst), .toggle_in(tg[0]), .enable(enable),
    .pwm_out(pw[0]), .duty(d0), .phase(p0)
  );

  led_breathe_pwm #(.STEP(3)) u3 (
    .clk(clk), .rst(rst), .toggle_in(tg[1]), .enable(enable),
    .pwm_out(pw[1]), .duty(d3), .phase(p3)
  );

  led_breathe_pwm #(.STEP(2)) u2 (
    .clk(clk), .rst(rst), .toggle_in(tg[2]), .enable(enable),
    .pwm_out(pw[2]), .duty(d2), .phase(p2)
  );

  led_breathe_pwm #(.STEP(255), .HOLD_TICKS(0)) un (
    .clk(clk), .rst(rst), .toggle_in(tg[3]), .enable(enable),
    .pwm_out(pw[3]), .duty(dn), .phase(pn)
  );

  function automatic int eff(int d);
`ifdef LED_BREATHE_GAMMA_EN
    return (d * d) >> 8;
`else
    return d;
`endif
  endfunction

  task automatic push(string tag, logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: observed %0d expected <none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick(int k, int n);
    repeat (n) begin
      @(negedge clk);
      tg[k] = ~tg[k];
    end
    @(negedge clk);
  endtask

  task automatic count_hi(int k, output int n);
    n = 0;
    repeat (2) @(negedge clk);
    repeat (256) begin
      @(negedge clk);
      if (pw[k] === 1'b1) n++;
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    int n;
    rst    = 1'b1;
    enable = 1'b1;
    tg     = '0;

    @(negedge clk);
    push("rst_duty", 0);   push("rst_phase", 0);
    push("rst_pwm", 0);    push("rst_dn", 0);
    check(32'(d0)); check(32'(p0)); check(32'(pw[0])); check(32'(dn));
    @(negedge clk);
    rst = 1'b0;

    tick(0, 255);
    push("ramp_duty", 255); push("ramp_phase", 1);
    check(32'(d0)); check(32'(p0));

    tick(0, 3);
    push("hold3_phase", 1);
    check(32'(p0));
    tick(0, 1);
    push("hold4_phase", 2); push("hold4_duty", 255);
    check(32'(p0)); check(32'(d0));
    tick(0, 1);
    push("fall1_duty", 254);
    check(32'(d0));

    tick(1, 84);
    push("s3_84_duty", 252); push("s3_84_phase", 0);
    check(32'(d3)); check(32'(p3));
    tick(1, 1);
    push("s3_85_duty", 255); push("s3_85_phase", 1);
    check(32'(d3)); check(32'(p3));

    tick(2, 127);
    push("s2_127_duty", 254); push("s2_127_phase", 0);
    check(32'(d2)); check(32'(p2));
    tick(2, 1);
    push("s2_sat_duty", 255); push("s2_sat_phase", 1);
    check(32'(d2)); check(32'(p2));

    push("pwm_255", 32'(eff(255)));
    count_hi(1, n);
    check(32'(n));

    tick(0, 190);
    push("d64_duty", 64); push("d64_phase", 2);
    check(32'(d0)); check(32'(p0));
    push("pwm_64", 32'(eff(64)));
    count_hi(0, n);
    check(32'(n));

    push("frz_duty", 64); push("frz_phase", 2); push("frz_pwm", 0);
    enable = 1'b0;
    tick(0, 10);
    repeat (2) @(negedge clk);
    check(32'(d0)); check(32'(p0));
    count_hi(0, n);
    check(32'(n));

    push("reen_duty", 64);
    enable = 1'b1;
    repeat (3) @(negedge clk);
    check(32'(d0));
    tick(0, 1);
    push("resume_duty", 63);
    check(32'(d0));

    tick(0, 63);
    push("d0_duty", 0); push("d0_phase", 3);
    check(32'(d0)); check(32'(p0));
    push("pwm_0", 0);
    count_hi(0, n);
    check(32'(n));
    tick(0, 4);
    push("holdlo_phase", 0); push("holdlo_duty", 0);
    check(32'(p0)); check(32'(d0));

    tick(3, 1);
    push("nh1_duty", 255); push("nh1_phase", 2);
    check(32'(dn)); check(32'(pn));
    tick(3, 1);
    push("nh2_duty", 0); push("nh2_phase", 0);
    check(32'(dn)); check(32'(pn));

    tick(0, 100);
    push("d100_duty", 100); push("d100_phase", 0);
    check(32'(d0)); check(32'(p0));

    @(posedge clk);
    #2;
    rst = 1'b1;
    tg  = '0;
    #1;
    push("mrst_duty", 0); push("mrst_phase", 0); push("mrst_pwm", 0);
    check(32'(d0)); check(32'(p0)); check(32'(pw[0]));
    @(negedge clk);
    rst = 1'b0;
    tick(0, 1);
    push("post_rst_duty", 1);
    check(32'(d0));

    tick(0, 127);
    push("d128_duty", 128);
    check(32'(d0));
    push("pwm_128", 32'(eff(128)));
    count_hi(0, n);
    check(32'(n));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
